sprite_pixel_writer: RTL and testbench

//  Consumer end of the sprite-drawer interface: sweeps WriteX/WriteY over one 640x480 frame, samples every

---
 rtl/sprite_pixel_writer_pkg.sv | 26 ++
 rtl/sprite_pixel_writer_if.sv | 25 ++
 rtl/sprite_pixel_writer_mux.sv | 25 ++
 rtl/sprite_pixel_writer.sv | 126 ++++++++++++
 tb/tb_sprite_pixel_writer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pixel_writer_pkg.sv
// sprite_pkg: frame geometry, bus widths, palette codes, writer state
// and the per-pixel bundle carried down the writer pipeline.
`timescale 1ns/1ps
package sprite_pkg;
  localparam int SCR_W  = 640;
  localparam int SCR_H  = 480;
  localparam int ROM_AW = 18;
  localparam int PIX_W  = 4;
  localparam int FB_AW  = 19;
  localparam int XY_W   = 10;

  localparam logic [PIX_W-1:0] BG_INDEX = 4'h0;
  localparam logic [PIX_W-1:0] TRANSP   = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } writer_state_t;

  typedef struct packed {
    logic             v;
    logic             hit;
    logic [FB_AW-1:0] addr;
  } pix_t;
endpackage

// File: rtl/sprite_pixel_writer_if.sv
// sprite_pixel_writer_if: frame-buffer write port.
// master drives we/addr/data, slave returns ready.
`timescale 1ns/1ps
interface sprite_pixel_writer_if;
  import sprite_pkg::*;

  logic             fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [PIX_W-1:0] fb_data;
  logic             fb_ready;

  modport master (
    output fb_we,
    output fb_addr,
    output fb_data,
    input  fb_ready
  );

  modport slave (
    input  fb_we,
    input  fb_addr,
    input  fb_data,
    output fb_ready
  );
endinterface

// File: rtl/sprite_pixel_writer_mux.sv
// sprite_priority_mux: picks the lowest-index drawer whose on flag
// is set; on/addrs in, hit + selected ROM address out.
`timescale 1ns/1ps
module sprite_priority_mux
  import sprite_pkg::*;
#(
  parameter int NSPR = 4
) (
  input  logic [NSPR-1:0]        on,
  input  logic [NSPR*ROM_AW-1:0] addrs,
  output logic                   hit,
  output logic [ROM_AW-1:0]      addr
);
  // walk from the top down so the lowest index wins
  always_comb begin
    hit  = 1'b0;
    addr = '0;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (on[i]) begin
        hit  = 1'b1;
        addr = addrs[ROM_AW*i +: ROM_AW];
      end
    end
  end
endmodule

// File: rtl/sprite_pixel_writer.sv
// sprite_pixel_writer: sweeps WriteX/WriteY, reads sprite ROM, writes
// one palette index per pixel via fb (master); busy/frame_done/overrun.
`timescale 1ns/1ps
module sprite_pixel_writer
  import sprite_pkg::*;
#(
  parameter int               NSPR     = 4,
  parameter int               SCR_W    = sprite_pkg::SCR_W,
  parameter int               SCR_H    = sprite_pkg::SCR_H,
  parameter logic [PIX_W-1:0] BG_INDEX = sprite_pkg::BG_INDEX,
  parameter logic [PIX_W-1:0] TRANSP   = sprite_pkg::TRANSP
) (
  input  logic                   Clk50,
  input  logic                   Reset_n,
  input  logic                   frame_start,
  output logic [XY_W-1:0]        WriteX,
  output logic [XY_W-1:0]        WriteY,
  input  logic [NSPR-1:0]        sprite_on,
  input  logic [NSPR*ROM_AW-1:0] sprite_addr,
  output logic [ROM_AW-1:0]      rom_addr,
  output logic                   rom_en,
  input  logic [PIX_W-1:0]       rom_data,
  sprite_pixel_writer_if.master  fb,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);
  localparam logic [XY_W-1:0] X_LAST = XY_W'(SCR_W - 1);
  localparam logic [XY_W-1:0] Y_LAST = XY_W'(SCR_H - 1);

  writer_state_t state, state_n;
  pix_t          s1, s2;
  logic [FB_AW-1:0]  pix_cnt;
  logic              sel_hit;
  logic [ROM_AW-1:0] sel_addr;
  logic stall, start_ok, last_xy, drain_done;

  sprite_priority_mux #(.NSPR(NSPR)) u_mux (
    .on    (sprite_on),
    .addrs (sprite_addr),
    .hit   (sel_hit),
    .addr  (sel_addr)
  );

  assign stall      = s2.v && !fb.fb_ready;
  // the frame_done cycle still counts as busy for a new start
  assign start_ok   = frame_start && (state == IDLE) && !frame_done;
  assign last_xy    = (WriteX == X_LAST) && (WriteY == Y_LAST);
  assign drain_done = s2.v && fb.fb_ready && !s1.v;

  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_ok)           state_n = SWEEP;
      SWEEP:   if (!stall && last_xy)  state_n = DRAIN;
      DRAIN:   if (drain_done)         state_n = IDLE;
      default:                         state_n = IDLE;
    endcase
  end

  // rom_en drops during a stall so the S2 pixel's rom_data holds
  always_comb begin
    busy   = 1'b0;
    rom_en = 1'b0;
    unique case (state)
      SWEEP, DRAIN: begin
        busy   = 1'b1;
        rom_en = !stall;
      end
      default: ;
    endcase
  end

  assign fb.fb_we   = s2.v;
  assign fb.fb_addr = s2.addr;
  assign fb.fb_data = (s2.hit && rom_data != TRANSP) ? rom_data
                                                     : BG_INDEX;

  // S0 = live WriteX/WriteY, S1 = ROM read in flight, S2 = fb write
  always_ff @(posedge Clk50 or negedge Reset_n) begin
    if (!Reset_n) begin
      WriteX     <= '0;
      WriteY     <= '0;
      pix_cnt    <= '0;
      rom_addr   <= '0;
      s1         <= '0;
      s2         <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && drain_done;
      if (start_ok)         overrun <= 1'b0;
      else if (frame_start) overrun <= 1'b1;
      if (start_ok) begin
        WriteX  <= '0;
        WriteY  <= '0;
        pix_cnt <= '0;
      end
      if (!stall) begin
        s2      <= s1;
        s1.v    <= (state == SWEEP);
        s1.hit  <= (state == SWEEP) && sel_hit;
        s1.addr <= pix_cnt;
        if (state == SWEEP && sel_hit) rom_addr <= sel_addr;
        if (state == SWEEP && !last_xy) begin
          pix_cnt <= pix_cnt + 1'b1;
          if (WriteX == X_LAST) begin
            WriteX <= '0;
            WriteY <= WriteY + 1'b1;
          end else begin
            WriteX <= WriteX + 1'b1;
          end
        end
      end
      if (state == DRAIN && drain_done) begin
        WriteX <= '0;
        WriteY <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sprite_pixel_writer.sv
// tb_sprite_pixel_writer: drawer + ROM models feed the writer; every
// frame's pixels are predicted into a queue and checked on each write.
`timescale 1ns/1ps
module tb_sprite_pixel_writer;
  import sprite_pkg::*;

  localparam int NSPR = 4;
  localparam int W    = 40;
  localparam int H    = 30;
  localparam int NPIX = W * H;

  logic               Clk50 = 1'b0;
  logic               Reset_n = 1'b0;
  logic               frame_start = 1'b0;
  logic [9:0]         WriteX, WriteY;
  logic [NSPR-1:0]    sprite_on;
  logic [NSPR*18-1:0] sprite_addr;
  logic [17:0]        rom_addr;
  logic               rom_en;
  logic [3:0]         rom_data = 4'h0;
  logic               busy, frame_done, overrun;

  sprite_pixel_writer_if fb();

  sprite_pixel_writer #(.NSPR(NSPR), .SCR_W(W), .SCR_H(H)) dut (
    .Clk50       (Clk50),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .WriteX      (WriteX),
    .WriteY      (WriteY),
    .sprite_on   (sprite_on),
    .sprite_addr (sprite_addr),
    .rom_addr    (rom_addr),
    .rom_en      (rom_en),
    .rom_data    (rom_data),
    .fb          (fb.master),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 Clk50 = ~Clk50;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input longint act,
                       input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, req, $time);
    end
  endtask

  // sprite rectangles and ROM contents
  int rx[NSPR], ry[NSPR], rw[NSPR], rh[NSPR], rb[NSPR];
  bit ren[NSPR];
  bit rom_const3 = 1'b0;
  logic [3:0] rom_ovr [int];

  function automatic bit in_rect(int i, int x, int y);
    return ren[i] && x >= rx[i] && x < rx[i] + rw[i] &&
           y >= ry[i] && y < ry[i] + rh[i];
  endfunction

  function automatic int spr_addr(int i, int x, int y);
    return rb[i] + (y - ry[i]) * rw[i] + (x - rx[i]);
  endfunction

  function automatic logic [3:0] rom_f(logic [17:0] a);
    if (rom_ovr.exists(int'(a))) return rom_ovr[int'(a)];
    if (rom_const3) return 4'h3;
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {2'b00, a[17:16]};
  endfunction

  always_comb begin
    sprite_on   = '0;
    sprite_addr = '0;
    for (int i = 0; i < NSPR; i++) begin
      if (in_rect(i, int'(WriteX), int'(WriteY))) begin
        sprite_on[i] = 1'b1;
        sprite_addr[18*i +: 18] =
          18'(spr_addr(i, int'(WriteX), int'(WriteY)));
      end
    end
  end

  always @(posedge Clk50)
    if (rom_en) rom_data <= rom_f(rom_addr);

  typedef struct {
    int         addr;
    logic [3:0] data;
  } exp_t;
  exp_t q[$];

  // expected image: lowest-index sprite wins, transparent -> bg
  function automatic void build_expect();
    exp_t e;
    int x;
    int y;
    bit found;
    logic [3:0] v;
    q.delete();
    for (int p = 0; p < NPIX; p++) begin
      x = p % W;
      y = p / W;
      found = 1'b0;
      e.addr = p;
      e.data = 4'h0;
      for (int i = 0; i < NSPR; i++) begin
        if (!found && in_rect(i, x, y)) begin
          found = 1'b1;
          v = rom_f(18'(spr_addr(i, x, y)));
          e.data = (v == 4'hF) ? 4'h0 : v;
        end
      end
      q.push_back(e);
    end
  endfunction

  function automatic void clear_cfg();
    for (int i = 0; i < NSPR; i++) begin
      ren[i] = 1'b0;
      rx[i] = 0; ry[i] = 0; rw[i] = 0; rh[i] = 0; rb[i] = 0;
    end
    rom_const3 = 1'b0;
    rom_ovr.delete();
  endfunction

  function automatic void set_rect(int i, int x, int y, int w, int h,
                                   int b);
    ren[i] = 1'b1;
    rx[i] = x; ry[i] = y; rw[i] = w; rh[i] = h; rb[i] = b;
  endfunction

  function automatic void random_cfg();
    clear_cfg();
    for (int i = 0; i < NSPR; i++) begin
      if ($urandom_range(0, 3) != 0)
        set_rect(i, int'($urandom_range(0, W - 1)),
                 int'($urandom_range(0, H - 1)),
                 int'($urandom_range(1, 20)),
                 int'($urandom_range(1, 15)),
                 int'($urandom_range(0, 200000)));
    end
  endfunction

  // monitor: pops on accepted writes, checks holds during stalls
  logic       stalled_prev = 1'b0;
  int         hold_addr;
  logic [3:0] hold_data;
  logic [9:0] hold_x;

  always @(negedge Clk50) begin : mon
    exp_t e;
    if (!Reset_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check("stall_we", fb.fb_we, 1);
        check("stall_addr", fb.fb_addr, hold_addr);
        check("stall_data", fb.fb_data, hold_data);
        check("stall_x", WriteX, hold_x);
      end
      stalled_prev = 1'b0;
      if (fb.fb_we && fb.fb_ready) begin
        if (q.size() == 0) begin
          check("extra_write", fb.fb_addr, -1);
        end else begin
          e = q.pop_front();
          check("wr_addr", fb.fb_addr, e.addr);
          check("wr_data", fb.fb_data, e.data);
        end
      end else if (fb.fb_we) begin
        check("stall_rom_en", rom_en, 0);
        stalled_prev = 1'b1;
        hold_addr = int'(fb.fb_addr);
        hold_data = fb.fb_data;
        hold_x = WriteX;
      end
    end
  end

  // one frame: spct = random stall %, stall_at = 5-cycle hold,
  // ovr_at = extra frame_start, rst_at = reset, dbl = start on done
  task automatic run_frame(input int spct, input int stall_at,
                           input int ovr_at, input int rst_at,
                           input bit dbl);
    int cyc = 0;
    int first = -1;
    int dones = 0;
    int hold = 0;
    bit ovr_chk = 1'b0;
    bit ovr_done = 1'b0;
    bit st_done = 1'b0;
    bit fin = 1'b0;
    build_expect();
    @(posedge Clk50); #1;
    frame_start = 1'b1;
    fb.fb_ready = 1'b1;
    while (!fin) begin
      @(posedge Clk50); #1;
      cyc++;
      frame_start = 1'b0;
      if (cyc == 1) begin
        check("start_busy", busy, 1);
        check("start_ovr_clr", overrun, 0);
      end
      if (ovr_chk) begin
        check("overrun_set", overrun, 1);
        check("overrun_busy", busy, 1);
        ovr_chk = 1'b0;
      end
      if (first < 0 && fb.fb_we) begin
        first = cyc;
        check("latency", first, 3);
      end
      if (fb.fb_we && fb.fb_addr == 19'(rst_at)) begin
        Reset_n = 1'b0;
        #1;
        check("rst_we", fb.fb_we, 0);
        check("rst_busy", busy, 0);
        q.delete();
        fb.fb_ready = 1'b1;
        repeat (2) @(posedge Clk50);
        #1 Reset_n = 1'b1;
        check("rst_x", WriteX, 0);
        return;
      end
      if (fb.fb_we && fb.fb_addr == 19'(ovr_at) && !ovr_done) begin
        frame_start = 1'b1;
        ovr_done = 1'b1;
        ovr_chk = 1'b1;
      end
      if (hold > 0) begin
        fb.fb_ready = 1'b0;
        hold--;
      end else if (fb.fb_we && fb.fb_addr == 19'(stall_at) &&
                   !st_done) begin
        fb.fb_ready = 1'b0;
        hold = 4;
        st_done = 1'b1;
      end else begin
        fb.fb_ready = ($urandom_range(0, 99) >= spct);
      end
      if (frame_done) begin
        dones++;
        check("done_q_empty", q.size(), 0);
        if (dbl) frame_start = 1'b1;
        fin = 1'b1;
      end
      if (cyc > 4 * NPIX + 50) begin
        check("timeout", cyc, 0);
        fin = 1'b1;
      end
    end
    @(posedge Clk50); #1;
    frame_start = 1'b0;
    fb.fb_ready = 1'b1;
    check("idle_busy", busy, 0);
    if (ovr_at >= 0) check("overrun_sticky", overrun, 1);
    if (dbl) check("dbl_overrun", overrun, 1);
    repeat (3) begin
      @(posedge Clk50); #1;
      if (frame_done) dones++;
      check("idle_we", fb.fb_we, 0);
    end
    check("done_once", dones, 1);
    check("idle_x", WriteX, 0);
    check("idle_y", WriteY, 0);
  endtask

  initial begin
    fb.fb_ready = 1'b1;
    clear_cfg();
    repeat (3) @(posedge Clk50);
    #1;
    check("rst_WriteX", WriteX, 0);
    check("rst_WriteY", WriteY, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_rom_en", rom_en, 0);
    check("rst_fb_we", fb.fb_we, 0);
    check("rst_busy0", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    Reset_n = 1'b1;

    clear_cfg();
    run_frame(0, -1, -1, -1, 1'b0);

    clear_cfg();
    rom_const3 = 1'b1;
    set_rect(1, 10, 5, 10, 5, 1000);
    run_frame(0, -1, -1, -1, 1'b0);

    clear_cfg();
    set_rect(0, 5, 6, 1, 1, 100);
    set_rect(2, 3, 6, 6, 2, 200);
    rom_ovr[100] = 4'h5;
    rom_ovr[202] = 4'h7;
    run_frame(0, -1, -1, -1, 1'b0);
    rom_ovr[100] = 4'hF;
    run_frame(0, -1, -1, -1, 1'b0);

    random_cfg();
    run_frame(0, 100, -1, -1, 1'b0);

    random_cfg();
    run_frame(20, -1, 500, -1, 1'b0);

    random_cfg();
    run_frame(0, -1, -1, -1, 1'b1);

    random_cfg();
    run_frame(10, -1, -1, -1, 1'b0);

    random_cfg();
    run_frame(15, -1, -1, 300, 1'b0);

    for (int k = 0; k < 3; k++) begin
      random_cfg();
      run_frame(30, int'($urandom_range(0, NPIX - 1)), -1, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
